// File: rtl/access_enable_pkg.sv
// Shared constants for the access-enable reader endpoint.
package access_enable_pkg;

    // Number of words the reader can hold internally.
    localparam int unsigned ACCESS_ENABLE_READER_DEPTH = 2;

    // Width of the occupancy count, able to represent 0..DEPTH.
    localparam int unsigned ACCESS_ENABLE_READER_LEVEL_W = $clog2(ACCESS_ENABLE_READER_DEPTH + 1);

endpackage

// File: rtl/access_enable_reader.sv
// access_enable_reader: drains a first-word-fall-through storage block
// (empty / read_enable / read_data) and re-presents its words on a
// registered valid/ready stream through a 2-entry queue.
// Optional flush input is enabled by defining ACCESS_ENABLE_READER_FLUSH_EN.
module access_enable_reader
    import access_enable_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                                    clock,
    input  logic                                    resetn,
`ifdef ACCESS_ENABLE_READER_FLUSH_EN
    input  logic                                    flush,
`endif
    input  logic                                    source_empty,
    output logic                                    source_read_enable,
    input  logic [WIDTH-1:0]                        source_read_data,
    output logic                                    output_valid,
    input  logic                                    output_ready,
    output logic [WIDTH-1:0]                        output_data,
    output logic [ACCESS_ENABLE_READER_LEVEL_W-1:0] level
);

    localparam logic [ACCESS_ENABLE_READER_LEVEL_W-1:0] LEVEL_FULL =
        ACCESS_ENABLE_READER_LEVEL_W'(ACCESS_ENABLE_READER_DEPTH);
    localparam logic [ACCESS_ENABLE_READER_LEVEL_W-1:0] LEVEL_ONE =
        ACCESS_ENABLE_READER_LEVEL_W'(1);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             flush_active;
    logic             push;
    logic             pop;

`ifdef ACCESS_ENABLE_READER_FLUSH_EN
    assign flush_active = flush;
`else
    assign flush_active = 1'b0;
`endif

    // Read only when the source has a word and there is room; never looks at
    // output_ready, so there is no combinational path from the consumer back
    // to the source.
    assign source_read_enable = resetn & ~source_empty & (level < LEVEL_FULL) & ~flush_active;

    assign output_valid = (level != '0) & ~flush_active;
    assign output_data  = entry0;

    assign push = source_read_enable;
    assign pop  = output_valid & output_ready;

    // Queue update: entry0 is the head, entry1 the tail, level the count.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            level  <= '0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush_active) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (level == '0) begin
                        entry0 <= source_read_data;
                    end else begin
                        entry1 <= source_read_data;
                    end
                    level <= level + LEVEL_ONE;
                end
                2'b01: begin
                    entry0 <= entry1;
                    level  <= level - LEVEL_ONE;
                end
                // Simultaneous push and pop only happens at level 1 (push
                // needs level<2, pop needs level>0): the new word replaces
                // the head and the count is unchanged.
                2'b11: begin
                    entry0 <= source_read_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_access_enable_reader.sv
// Self-checking bench for access_enable_reader. The source is modelled as a
// first-word-fall-through queue; every word read from it is pushed to an
// expected-results queue and compared when the DUT hands it downstream.
module tb_access_enable_reader;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         resetn;
    logic         flush;
    logic         source_empty;
    logic         source_read_enable;
    logic [W-1:0] source_read_data;
    logic         output_valid;
    logic         output_ready;
    logic [W-1:0] output_data;
    logic [1:0]   level;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];

    int unsigned n_vec   = 0;
    int unsigned n_bad   = 0;
    int unsigned n_reads = 0;
    int unsigned n_outs  = 0;
    int unsigned cyc     = 0;

    always #5 clock = ~clock;

    access_enable_reader #(.WIDTH(W)) dut (
        .clock              (clock),
        .resetn             (resetn),
`ifdef ACCESS_ENABLE_READER_FLUSH_EN
        .flush              (flush),
`endif
        .source_empty       (source_empty),
        .source_read_enable (source_read_enable),
        .source_read_data   (source_read_data),
        .output_valid       (output_valid),
        .output_ready       (output_ready),
        .output_data        (output_data),
        .level              (level)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_source();
        source_empty     = (src_q.size() == 0);
        source_read_data = (src_q.size() == 0) ? 8'hEE : src_q[0];
    endtask

    // One clock: sample and score at the falling edge, let the edge happen,
    // then update the source model and settle just after the rising edge.
    task automatic step();
        logic do_read;
        logic clr;
        @(negedge clock);
        check_value("rd_when_empty", {31'd0, source_read_enable & source_empty}, 32'd0);
        check_value("level_max", {31'd0, level <= 2'd2}, 32'd1);
        if (output_valid && output_ready) begin
            if (exp_q.size() == 0) check_value("spurious_out", 32'd1, 32'd0);
            else check_value("out_data", {24'd0, output_data}, {24'd0, exp_q.pop_front()});
            n_outs++;
        end
        do_read = source_read_enable;
        if (do_read) begin
            exp_q.push_back(source_read_data);
            n_reads++;
        end
        clr = !resetn || flush;
        @(posedge clock);
        #1;
        if (do_read && src_q.size() > 0) void'(src_q.pop_front());
        if (clr) exp_q.delete();
        drive_source();
        #1;
        cyc++;
    endtask

    task automatic drain();
        output_ready = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && level == 2'd0 && src_q.size() == 0) break;
            step();
        end
        check_value("drain_done", {31'd0, exp_q.size() == 0 && level == 2'd0}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r0;
        int unsigned o0;
        int unsigned gen;

        resetn       = 1'b0;
        flush        = 1'b0;
        output_ready = 1'b0;
        src_q.push_back(8'h3C);
        drive_source();

        // Reset held with a non-empty source: nothing may be read.
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("rst_rd_en", {31'd0, source_read_enable}, 32'd0);
            check_value("rst_valid", {31'd0, output_valid}, 32'd0);
            check_value("rst_level", {30'd0, level}, 32'd0);
            check_value("rst_data", {24'd0, output_data}, 32'd0);
        end
        resetn = 1'b1;
        #1;
        check_value("rel_rd_en", {31'd0, source_read_enable}, 32'd1);
        step();
        check_value("rel_valid", {31'd0, output_valid}, 32'd1);
        check_value("rel_data", {24'd0, output_data}, 32'h3C);
        check_value("rel_level", {30'd0, level}, 32'd1);
        drain();

        // Streaming with the consumer always ready.
        for (int i = 1; i <= 16; i++) src_q.push_back(W'(i));
        drive_source();
        output_ready = 1'b1;
        #1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_value("strm_valid", {31'd0, output_valid}, 32'd1);
            check_value("strm_data", {24'd0, output_data}, i);
            check_value("strm_level", {30'd0, level}, 32'd1);
        end
        step();
        check_value("strm_end_valid", {31'd0, output_valid}, 32'd0);
        drain();

        // Backpressure: only two words may be taken while the consumer stalls.
        output_ready = 1'b0;
        src_q.push_back(8'hA0);
        src_q.push_back(8'hA1);
        src_q.push_back(8'hA2);
        drive_source();
        r0 = n_reads;
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("bp_hold_data", {24'd0, output_data}, 32'hA0);
        end
        check_value("bp_reads", n_reads - r0, 32'd2);
        check_value("bp_level", {30'd0, level}, 32'd2);
        check_value("bp_rd_en", {31'd0, source_read_enable}, 32'd0);
        check_value("bp_valid", {31'd0, output_valid}, 32'd1);
        output_ready = 1'b1;
        #1;
        step();
        check_value("bp_data1", {24'd0, output_data}, 32'hA1);
        check_value("bp_resume", {31'd0, source_read_enable}, 32'd1);
        step();
        check_value("bp_data2", {24'd0, output_data}, 32'hA2);
        check_value("bp_valid2", {31'd0, output_valid}, 32'd1);
        step();
        check_value("bp_empty", {31'd0, output_valid}, 32'd0);
        drain();

        // Single-entry source: one word written once.
        r0 = n_reads;
        o0 = n_outs;
        src_q.push_back(8'h5A);
        drive_source();
        output_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) step();
        check_value("se_reads", n_reads - r0, 32'd1);
        check_value("se_outs", n_outs - o0, 32'd1);
        check_value("se_src_empty", {31'd0, source_empty}, 32'd1);

        // Randomised source availability and consumer readiness.
        o0  = n_outs;
        gen = 0;
        for (int i = 0; i < 20000; i++) begin
            if (gen == 1000 && src_q.size() == 0 && exp_q.size() == 0 && level == 2'd0) break;
            if (gen < 1000 && src_q.size() < 4 && $urandom_range(1, 0) == 1) begin
                src_q.push_back(W'($urandom_range(255, 0)));
                gen++;
            end
            drive_source();
            output_ready = ($urandom_range(3, 0) != 0);
            #1;
            step();
        end
        check_value("rnd_outs", n_outs - o0, 32'd1000);
        drain();

`ifdef ACCESS_ENABLE_READER_FLUSH_EN
        // Flush discards held words but leaves the source untouched.
        output_ready = 1'b0;
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
        drive_source();
        step();
        step();
        check_value("fl_level_pre", {30'd0, level}, 32'd2);
        src_q.push_back(8'h33);
        drive_source();
        flush = 1'b1;
        #1;
        check_value("fl_valid", {31'd0, output_valid}, 32'd0);
        check_value("fl_rd_en", {31'd0, source_read_enable}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check_value("fl_level_post", {30'd0, level}, 32'd0);
        check_value("fl_valid_post", {31'd0, output_valid}, 32'd0);
        output_ready = 1'b1;
        #1;
        step();
        check_value("fl_next_valid", {31'd0, output_valid}, 32'd1);
        check_value("fl_next_data", {24'd0, output_data}, 32'h33);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/access_enable_reader.md
Name: access_enable_reader

Overview:
- Consumer-side endpoint for access-enable storage: drains a buffer or FIFO exposing empty/read_enable/read_data, such as the single-entry buffer.
- Issues read_enable only when safe, never reading when empty, which the storage blocks do not check themselves.
- Re-presents the words on a registered valid/ready stream with a 2-entry internal queue, giving full throughput and no combinational ready-to-read_enable path.
- Sits between access-enable storage and valid/ready consumers.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous reset, active-low.
- source_empty  input  1  source storage empty flag.
- source_read_enable  output  1  pop request to source storage.
- source_read_data  input  WIDTH  source head word; valid whenever source_empty=0 (first-word-fall-through).
- output_valid  output  1  output word available.
- output_ready  input  1  downstream accepts the word.
- output_data  output  WIDTH  output word.
- level  output  2  internal occupancy, 0..2.

Behaviour:
- Clocking and reset: one clock, clock. Reset resetn is synchronous and active-low, sampled only on the rising edge of clock.
- Reset values: level=0, both entries=0, output_valid=0, output_data=0.
  - source_read_enable=0 in any cycle where resetn=0, gated combinationally.
- Storage: entry0 is the head and entry1 is the tail; level is the registered count.
- source_read_enable = resetn & ~source_empty & (level<2).
  - Depends only on source_empty and registers; never on output_ready.
- push = source_read_enable; word captured is source_read_data in the same cycle.
- pop = output_valid & output_ready.
- output_valid = (level!=0). output_data = entry0.
  - Both are registered: stable while valid and not ready.
- Next-state on each clock edge:
  - push only: the word goes to entry[level]; level+1.
  - pop only: entry0<=entry1; level-1.
  - push & pop:
    - level=1: entry0<=source data; level stays 1.
    - level=2: not possible, because push requires level<2.
  - neither: hold.
- Latency: source word visible with empty=0 in cycle N is presented on output_valid in cycle N+1, if level<2 in N.
- Throughput: with output_ready held at 1, steady state at level=1 transfers one word per cycle.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Backpressure: with output_ready=0, at most two words are read before source_read_enable drops to 0 at level=2.
  - Reading resumes the cycle after the first pop.
- Empty source: source_read_enable=0; the internal queue drains normally.
- output_ready with output_valid=0: ignored.
- Reset mid-operation: all held words are discarded on the edge with resetn=0.
  - No source read occurs in that cycle; the source contents are untouched.
- Arithmetic: level never exceeds 2 and never underflows.

Optional Feature:
- Macro: ACCESS_ENABLE_READER_FLUSH_EN.
- With the macro defined: extra input port flush (1 bit).
  - While flush=1: source_read_enable=0, output_valid=0, pop ignored; level cleared to 0 at the edge. Entry contents are don't-care.
  - Source storage is not drained by flush.
- Without the macro: no flush port, and the logic is exactly as above.

Decomposition:
- Shared package access_enable_pkg:
  - localparam ACCESS_ENABLE_READER_DEPTH=2.
  - Level width constant $clog2(DEPTH+1)=2.
- No sub-module: the 2-entry queue is inline; a separate module adds nothing.

Test Plan:
- Reset: hold resetn=0 with source_empty=0 for 3 cycles.
  - Required: source_read_enable=0 throughout; output_valid=0; level=0. Release: read_enable=1 on the next cycle.
- Streaming: source supplies 0x01..0x10 continuously; output_ready=1.
  - Required: output words 0x01..0x10 in order on 16 consecutive cycles, first valid 1 cycle after the first read; level=1 steady.
- Backpressure: output_ready=0 while the source holds 0xA0,0xA1,0xA2.
  - Required: exactly 2 reads, level=2, output_data=0xA0 stable. Set ready=1: outputs 0xA0,0xA1,0xA2 with no gap and no duplicate.
- Single-entry source: connect the single-entry simple buffer as source; write 0x5A once.
  - Required: one read_enable pulse, buffer goes empty, output 0x5A once, never a read while empty (assertion).
- Randomized ready and empty toggling, 1000 words.
  - Required: scoreboard match; assert no read_enable when source_empty=1; level<=2.
- Flush (ACCESS_ENABLE_READER_FLUSH_EN): level=2 holding 0x11,0x22; pulse flush one cycle.
  - Required: output_valid=0 during the pulse, level=0 after; the next source word 0x33 appears as the next output.
